// File: rtl/serial_adder_if.sv
// Operation request / result bundle for the bit-serial adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, mode, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, mode, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one shared NAND-only full-adder cell processes
// one bit per clock, LSB first. Subtract is done as a + ~b + 1.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last answer
// RUN   | one bit per edge, returns to IDLE after bit WIDTH-1
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;
    logic             cout_q;

    logic n1, n2, n3, n4, n5, n6, n7;
    logic fa_sum_d;
    logic fa_carry_d;
    logic last_bit;

    // Shared full-adder cell, nine 2-input NANDs; n4 is a^b.
    assign n1         = ~(a_q[0] & b_q[0]);
    assign n2         = ~(a_q[0] & n1);
    assign n3         = ~(b_q[0] & n1);
    assign n4         = ~(n2 & n3);
    assign n5         = ~(n4 & carry_q);
    assign n6         = ~(n4 & n5);
    assign n7         = ~(carry_q & n5);
    assign fa_sum_d   = ~(n6 & n7);
    assign fa_carry_d = ~(n1 & n5);

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Operands shift right so bit 0 always feeds the cell; sum fills from the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.mode ? ~bus.b : bus.b;
                        carry_q <= bus.mode ? 1'b1 : bus.cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= {fa_sum_d, sum_q[WIDTH-1:1]};
                    carry_q <= fa_carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_bit) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        cout_q  <= fa_carry_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 mode  input  1  0 = add (a+b+cin), 1 = subtract (a-b); captured with start.
REQ-006 a  input  WIDTH  operand A; captured with start.
REQ-007 b  input  WIDTH  operand B; captured with start.
REQ-008 cin  input  1  carry-in for add; ignored when mode=1.
REQ-009 busy  output  1  high while the operation is in progress.
REQ-010 done  output  1  one-cycle pulse: sum/cout valid.
REQ-011 sum  output  WIDTH  result, LSB-first serial accumulation.
REQ-012 cout  output  1  carry-out for add; not-borrow for subtract (1 = a>=b unsigned).

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-014 In IDLE, start=1 on a rising edge SHALL capture a, b, mode and cin, load the carry flop with cin (mode=0) or 1 (mode=1), clear the bit counter, and move to RUN.
REQ-015 In subtract mode the captured b SHALL be bitwise inverted, giving a + ~b + 1.
REQ-016 In RUN, each rising edge SHALL process exactly one bit, LSB first: one full-adder cell combines a[i], b'[i] and the carry flop; sum bit i is stored and the carry flop is updated.
REQ-017 The full-adder cell SHALL be built only from two-input NAND gates (9 NANDs), with one instance shared across all bits.
REQ-018 The bit counter SHALL be $clog2(WIDTH) bits wide and increment once per RUN cycle.
REQ-019 On the edge that processes bit WIDTH-1, the FSM SHALL return to IDLE, drive cout from the final carry, and assert done for the next cycle only.
REQ-020 Latency SHALL be fixed: with start sampled at edge k, busy SHALL be high from edge k+1 through edge k+WIDTH, and done SHALL be high for the cycle after edge k+WIDTH.
REQ-021 busy SHALL be 1 exactly when the state is RUN.
REQ-022 sum and cout SHALL be don't-care while busy=1.
REQ-023 sum and cout SHALL be held stable from done until the next accepted start.
REQ-024 start while busy=1 SHALL be ignored, with no effect on the operation in progress and no queuing.
REQ-025 start high in the done cycle SHALL be accepted, because the state is already IDLE; back-to-back operations therefore have no bubble.
REQ-026 Overflow SHALL wrap modulo 2^WIDTH, with the carry reported only on cout.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0 and captured operands=0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL abort it: no done pulse follows, and the next start after rst_n deasserts SHALL begin a clean operation.
REQ-029 start SHALL be ignored while rst_n=0.

Verification
REQ-030 WIDTH=8, mode=0, a=0x5A, b=0x3C, cin=0 -> done exactly 8 cycles after the start edge, sum=0x96, cout=0.
REQ-031 WIDTH=8, mode=0, a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1; a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
REQ-032 WIDTH=8, mode=1: a=0x10, b=0x01 -> sum=0x0F, cout=1; a=0x01, b=0x02 -> sum=0xFF, cout=0; cin=1 has no effect on either result.
REQ-033 Start pulsed at cycle 3 of a busy operation with different operands -> first result unchanged, no extra done pulse.
REQ-034 rst_n pulsed low at cycle 4 of RUN -> all outputs 0 asynchronously and no done pulse; then a=0x03, b=0x04 -> sum=0x07.
REQ-035 Exhaustive sweep at WIDTH=4, all a, b, cin and mode with back-to-back starts on each done cycle -> every result matches the arithmetic model, one done per operation, no idle cycles between operations.
